engine_run_sequencer: RTL and testbench

Run-level controller sitting between the MMIO register slave and the read/write AXI master engines of the single-engine action. It accepts one run command at a time and issues `engine_start_pulse` to the read and/or write master: read-only, write-only, concurrent, or read-then-write. It collects the engines' done pulses and error codes, measures run duration and enforces an optional watchdog. It then reports a single completion pulse plus sticky status to software.

---
 rtl/engine_run_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_engine_run_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/engine_run_sequencer.sv
// engine_run_sequencer: run-level controller for the single-engine action.
// Accepts one run command at a time, pulses the read and/or write engine start,
// collects done pulses and error codes, counts run cycles and reports completion.
// Optional watchdog is compiled in when the macro ENGINE_WATCHDOG_EN is defined.
module engine_run_sequencer #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cmd_start,
    input  logic [1:0]           cmd_mode,
    input  logic [31:0]          rd_number,
    input  logic [31:0]          wr_number,
    input  logic [CNT_WIDTH-1:0] timeout_cycles,
    input  logic                 rd_done_pulse,
    input  logic [1:0]           rd_error,
    input  logic                 wr_done_pulse,
    input  logic [1:0]           wr_error,
    output logic                 rd_start_pulse,
    output logic                 wr_start_pulse,
    output logic                 busy,
    output logic                 run_done_pulse,
    output logic [7:0]           run_status,
    output logic [CNT_WIDTH-1:0] run_cycles
);

    typedef enum logic [2:0] {
        StIdle,
        StRdRun,
        StWrRun,
        StBothRun,
        StFinish
    } state_e;

    state_e               state_q, state_d;
    logic                 rw_mode_q, rw_mode_d;   // mode 11: write follows read
    logic                 wr_zero_q, wr_zero_d;   // latched write number was 0
    logic                 rd_seen_q, rd_seen_d;
    logic                 wr_seen_q, wr_seen_d;
    logic                 rd_start_q, rd_start_d;
    logic                 wr_start_q, wr_start_d;
    logic [5:0]           status_q, status_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 run_state;

`ifdef ENGINE_WATCHDOG_EN
    logic [CNT_WIDTH-1:0] limit_q, limit_d;
`else
    logic                 unused_timeout;
    assign unused_timeout = ^timeout_cycles;
`endif

    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign run_state = (state_q == StRdRun) || (state_q == StWrRun) || (state_q == StBothRun);

    // Next-state, run bookkeeping and status accumulation
    always_comb begin
        state_d    = state_q;
        rw_mode_d  = rw_mode_q;
        wr_zero_d  = wr_zero_q;
        rd_seen_d  = rd_seen_q;
        wr_seen_d  = wr_seen_q;
        rd_start_d = 1'b0;
        wr_start_d = 1'b0;
        status_d   = status_q;
        cnt_d      = cnt_q;
`ifdef ENGINE_WATCHDOG_EN
        limit_d    = limit_q;
`endif

        if (run_state) begin
            cnt_d = cnt_inc;
            if (rd_done_pulse) status_d[1:0] = status_q[1:0] | rd_error;
            if (wr_done_pulse) status_d[3:2] = status_q[3:2] | wr_error;
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    rw_mode_d = (cmd_mode == 2'b11);
                    wr_zero_d = (wr_number == '0);
                    status_d  = '0;
                    cnt_d     = '0;
`ifdef ENGINE_WATCHDOG_EN
                    limit_d   = timeout_cycles;
`endif
                    // A zero-length engine is never started and counts as already done
                    rd_seen_d = (rd_number == '0);
                    wr_seen_d = (wr_number == '0);
                    unique case (cmd_mode)
                        2'b00, 2'b11: begin
                            state_d    = StRdRun;
                            rd_start_d = (rd_number != '0);
                        end
                        2'b01: begin
                            state_d    = StWrRun;
                            wr_start_d = (wr_number != '0);
                        end
                        default: begin
                            state_d    = StBothRun;
                            rd_start_d = (rd_number != '0);
                            wr_start_d = (wr_number != '0);
                        end
                    endcase
                end
            end
            StRdRun: begin
                if (rd_seen_q || rd_done_pulse) begin
                    if (rw_mode_q && !wr_zero_q) begin
                        state_d    = StWrRun;
                        wr_start_d = 1'b1;
                        wr_seen_d  = 1'b0;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StWrRun: begin
                if (wr_seen_q || wr_done_pulse) state_d = StFinish;
            end
            StBothRun: begin
                rd_seen_d = rd_seen_q | rd_done_pulse;
                wr_seen_d = wr_seen_q | wr_done_pulse;
                if (rd_seen_d && wr_seen_d) state_d = StFinish;
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef ENGINE_WATCHDOG_EN
        // Timeout in the run cycle whose count reaches the limit; engines keep going
        if (run_state && (limit_q != '0) && (cnt_inc == limit_q)) begin
            status_d[4] = 1'b1;
            state_d     = StFinish;
            wr_start_d  = 1'b0;
        end
`endif

        if (cmd_start && (state_q != StIdle)) status_d[5] = 1'b1;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            rw_mode_q  <= 1'b0;
            wr_zero_q  <= 1'b0;
            rd_seen_q  <= 1'b0;
            wr_seen_q  <= 1'b0;
            rd_start_q <= 1'b0;
            wr_start_q <= 1'b0;
            status_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rw_mode_q  <= rw_mode_d;
            wr_zero_q  <= wr_zero_d;
            rd_seen_q  <= rd_seen_d;
            wr_seen_q  <= wr_seen_d;
            rd_start_q <= rd_start_d;
            wr_start_q <= wr_start_d;
            status_q   <= status_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef ENGINE_WATCHDOG_EN
    // Watchdog limit latched on command accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) limit_q <= '0;
        else         limit_q <= limit_d;
    end
`endif

    assign rd_start_pulse = rd_start_q;
    assign wr_start_pulse = wr_start_q;
    assign busy           = (state_q != StIdle);
    assign run_done_pulse = (state_q == StFinish);
    assign run_status     = {2'b00, status_q};
    assign run_cycles     = cnt_q;

endmodule

// File: tb/tb_engine_run_sequencer.sv
// Testbench for engine_run_sequencer: directed runs from the test plan plus
// randomized runs, checked against a timeline model computed per run.
// Watchdog expectations apply when ENGINE_WATCHDOG_EN is defined.
module tb_engine_run_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_start;
    logic [1:0]  cmd_mode;
    logic [31:0] rd_number, wr_number, timeout_cycles;
    logic        rd_done_pulse, wr_done_pulse;
    logic [1:0]  rd_error, wr_error;
    logic        rd_start_pulse, wr_start_pulse, busy, run_done_pulse;
    logic [7:0]  run_status;
    logic [31:0] run_cycles;

    int total = 0;
    int bad   = 0;

    engine_run_sequencer #(.CNT_WIDTH(32)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cmd_start      (cmd_start),
        .cmd_mode       (cmd_mode),
        .rd_number      (rd_number),
        .wr_number      (wr_number),
        .timeout_cycles (timeout_cycles),
        .rd_done_pulse  (rd_done_pulse),
        .rd_error       (rd_error),
        .wr_done_pulse  (wr_done_pulse),
        .wr_error       (wr_error),
        .rd_start_pulse (rd_start_pulse),
        .wr_start_pulse (wr_start_pulse),
        .busy           (busy),
        .run_done_pulse (run_done_pulse),
        .run_status     (run_status),
        .run_cycles     (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_start      = 1'b0;
        cmd_mode       = 2'b00;
        rd_number      = '0;
        wr_number      = '0;
        timeout_cycles = '0;
        rd_done_pulse  = 1'b0;
        wr_done_pulse  = 1'b0;
        rd_error       = 2'b00;
        wr_error       = 2'b00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_start"}, rd_start_pulse, 0);
        chk({tag, "_wr_start"}, wr_start_pulse, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, run_done_pulse, 0);
        chk({tag, "_status"}, run_status, 0);
        chk({tag, "_cycles"}, run_cycles, 0);
    endtask

    // One run. Command accepted in cycle 0; an active engine is done dr/dw cycles
    // after its start pulse. drop_at: cycle of an extra cmd_start (-1 for none).
    task automatic do_run(input logic [1:0] mode, input logic [31:0] rn, input logic [31:0] wn,
                          input int dr, input int dw, input logic [1:0] re, input logic [1:0] we,
                          input int drop_at, input logic [31:0] lim);
        bit ract, wact, tmo;
        int tr, tw, rs, ws, last;
        logic [7:0] st;
        ract = (mode != 2'b01) && (rn != 0);
        wact = (mode != 2'b00) && (wn != 0);
        rs   = ract ? 1 : -1;
        tr   = ract ? 1 + dr : 1;
        if (mode == 2'b11) begin
            ws = wact ? tr + 1 : -1;
            tw = wact ? tr + 1 + dw : tr;
        end else begin
            ws = wact ? 1 : -1;
            tw = wact ? 1 + dw : 1;
        end
        last = (tr > tw) ? tr : tw;
        tmo  = 1'b0;
`ifdef ENGINE_WATCHDOG_EN
        if (lim != 0 && lim <= 32'(last)) begin
            last = int'(lim);
            tmo  = 1'b1;
        end
`endif
        if (ws > last) ws = -1;
        wact = wact && (ws != -1);
        st = '0;
        if (ract && tr <= last) st[1:0] = re;
        if (wact && tw <= last) st[3:2] = we;
        st[4] = tmo;
        if (drop_at >= 1 && drop_at <= last) st[5] = 1'b1;

        for (int k = 0; k <= last + 3; k++) begin
            @(posedge clk);
            #1;
            cmd_start      = (k == 0) || (k == drop_at && drop_at <= last);
            cmd_mode       = (k == 0) ? mode : 2'($urandom);
            rd_number      = (k == 0) ? rn : $urandom;
            wr_number      = (k == 0) ? wn : $urandom;
            timeout_cycles = (k == 0) ? lim : $urandom;
            rd_done_pulse  = (ract && k == tr) || (k > last && k <= last + 2 && $urandom_range(0, 1) == 1);
            wr_done_pulse  = (wact && k == tw) || (k > last && k <= last + 2 && $urandom_range(0, 1) == 1);
            rd_error       = (ract && k == tr) ? re : 2'($urandom);
            wr_error       = (wact && k == tw) ? we : 2'($urandom);
            @(negedge clk);
            chk("rd_start", rd_start_pulse, k == rs);
            chk("wr_start", wr_start_pulse, k == ws);
            chk("busy", busy, k >= 1 && k <= last + 1);
            chk("run_done", run_done_pulse, k == last + 1);
            if (k >= 1 && k <= last) chk("cycles_run", run_cycles, 32'(k - 1));
            if (k >= last + 1) begin
                chk("run_cycles", run_cycles, 32'(last));
                chk("run_status", run_status, st);
            end
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        int drop;
        logic [31:0] lim;
        resetn = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Mode 00, read done in the 20th run cycle
        do_run(2'b00, 4, 0, 19, 0, 2'b00, 2'b00, -1, 0);
        // Mode 11, write error 2'b10, 26 run cycles in total
        do_run(2'b11, 8, 8, 10, 14, 2'b00, 2'b10, -1, 0);
        // Mode 10, both dones in the same cycle
        do_run(2'b10, 8, 8, 7, 7, 2'b01, 2'b00, -1, 0);
        // Mode 10 with a zero-length write, then both zero
        do_run(2'b10, 3, 0, 5, 0, 2'b11, 2'b00, -1, 0);
        do_run(2'b10, 0, 0, 0, 0, 2'b00, 2'b00, -1, 0);
        // Mode 11 with zero-length read, mode 01
        do_run(2'b11, 0, 6, 0, 4, 2'b00, 2'b01, -1, 0);
        do_run(2'b01, 0, 6, 0, 9, 2'b00, 2'b11, -1, 0);
        // Extra command mid-run is dropped and flagged
        do_run(2'b00, 2, 0, 9, 0, 2'b10, 2'b00, 3, 0);
`ifdef ENGINE_WATCHDOG_EN
        do_run(2'b10, 4, 4, 1000, 1000, 2'b00, 2'b00, -1, 50);
`endif

        // Reset during a concurrent run clears everything immediately
        @(posedge clk);
        #1;
        cmd_start = 1'b1;
        cmd_mode  = 2'b10;
        rd_number = 5;
        wr_number = 5;
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        do_run(2'b10, 5, 5, 3, 6, 2'b10, 2'b01, -1, 0);

        for (int i = 0; i < 25; i++) begin
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : -1;
`ifdef ENGINE_WATCHDOG_EN
            lim = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
`else
            lim = $urandom;
`endif
            do_run(2'($urandom),
                   ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 64),
                   ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 64),
                   int'($urandom_range(1, 15)), int'($urandom_range(1, 15)),
                   2'($urandom), 2'($urandom), drop, lim);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
